fu_complete_buffer: RTL and testbench

// - FU-side end of the CDB completion handshake. It sits between one functional unit's

---
 rtl/fu_complete_buffer.sv | 135 +++++++++++++
 tb/tb_fu_complete_buffer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fu_complete_buffer.sv
// ---------------------------------------------------------------------------
// fu_complete_buffer
//
// This is the functional-unit end of the CDB completion handshake. It sits
// between one FU's writeback stage and the CDB arbiter. Completed destination
// tags are queued in a circular FIFO. The head tag is offered to the arbiter one
// request at a time. A tag is retired only when the arbiter's registered grant
// comes back one cycle later, during WAIT, so no tag is broadcast twice and no
// tag is lost.
//
// Parameters
//   TAG_W  physical register tag width (default $clog2(`PREG_NUMBER) = 6)
//   DEPTH  FIFO entries; must be a power of two and >= 2 (default 4)
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-low reset
//   push_i         in   the FU has a completed tag this cycle
//   push_tag_i     in   tag to enqueue
//   full_o         out  buffer holds DEPTH tags; the FU must not push
//   count_o        out  number of valid entries
//   complete_o     out  CDB request
//   tag_o          out  tag offered on the CDB (0 when the buffer is empty)
//   complete_en_i  in   registered grant from the CDB arbiter
//   flush_i        in   squash: drop every queued tag
//
// Configuration macro
//   CB_BYPASS_EN   If defined, a push into an empty, idle buffer is offered
//                  combinationally in the same cycle. The tag is still stored,
//                  and the FSM goes straight to WAIT. If undefined, all outputs
//                  come from registered state only.
// ---------------------------------------------------------------------------
`ifndef PREG_NUMBER
`define PREG_NUMBER 64
`endif

module fu_complete_buffer #(
  parameter int TAG_W = $clog2(`PREG_NUMBER),
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [TAG_W-1:0]         push_tag_i,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     complete_o,
  output logic [TAG_W-1:0]         tag_o,
  input  logic                     complete_en_i,
  input  logic                     flush_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [TAG_W-1:0] mem [DEPTH];
  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    count, count_nxt;
  logic             push_ok, pop, bypass_hit;

  // Full is derived from the registered count. A push while full is dropped,
  // even when a pop happens in the same cycle.
  assign full_o  = (count == CW'(DEPTH));
  assign count_o = count;
  assign push_ok = push_i && !full_o;
  // A grant pops only in WAIT. The non-empty guard keeps a stale grant from
  // underflowing the buffer.
  assign pop     = (state == ST_WAIT) && complete_en_i && (count != '0);

  assign count_nxt = count + CW'(push_ok) - CW'(pop);

`ifdef CB_BYPASS_EN
  assign bypass_hit = (state == ST_IDLE) && (count == '0) && push_i;
`else
  assign bypass_hit = 1'b0;
`endif

  // NOTE: every combinational output gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        // Any grant seen in IDLE is stale (for example, after a flush) and is ignored.
        if (bypass_hit)                     state_nxt = ST_WAIT;
        else if (count != '0 || push_i)     state_nxt = ST_REQ;
      end
      ST_REQ:  state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (complete_en_i) state_nxt = (count_nxt != '0) ? ST_REQ : ST_IDLE;
        else               state_nxt = ST_REQ;  // denied: re-offer the same head
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (flush_i) state_nxt = ST_IDLE;
  end

  assign complete_o = (state == ST_REQ) || bypass_hit;
  assign tag_o      = bypass_hit      ? push_tag_i :
                      (count != '0)   ? mem[head]  : '0;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // always_ff block sees the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      state <= ST_IDLE;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (push_ok) tail <= tail + PW'(1);
      if (pop)     head <= head + PW'(1);
    end
  end

  // NOTE: the tag storage has no reset. Entries are never read unless count
  // says they are valid, so clearing them would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem[tail] <= push_tag_i;
  end

endmodule

// File: tb/tb_fu_complete_buffer.sv
// ---------------------------------------------------------------------------
// tb_fu_complete_buffer
//
// Directed bench for fu_complete_buffer.
//   - A table of {inputs, expected outputs} rows is applied one clock at a time.
//     Outputs are compared on the falling edge after each rising edge.
//   - Hand-written sequences cover the flush corner cases and, when
//     CB_BYPASS_EN is defined, the same-cycle bypass path.
//   - A monitor checks that complete_o is never high on two consecutive edges.
// ---------------------------------------------------------------------------
module tb_fu_complete_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       push_i;
  logic [5:0] push_tag_i;
  logic       full_o;
  logic [2:0] count_o;
  logic       complete_o;
  logic [5:0] tag_o;
  logic       complete_en_i;
  logic       flush_i;

  int checks = 0;
  int errors = 0;

  fu_complete_buffer dut (
    .clk           (clk),
    .reset         (reset),
    .push_i        (push_i),
    .push_tag_i    (push_tag_i),
    .full_o        (full_o),
    .count_o       (count_o),
    .complete_o    (complete_o),
    .tag_o         (tag_o),
    .complete_en_i (complete_en_i),
    .flush_i       (flush_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       push;
    logic [5:0] tag;
    logic       en;
    logic       flush;
    logic       exp_comp;
    logic [5:0] exp_tag;
    logic [2:0] exp_cnt;
    logic       exp_full;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic p, logic [5:0] t, logic e, logic f,
                              logic c, logic [5:0] et, logic [2:0] n, logic fl);
    vec_t v;
    v.push = p; v.tag = t; v.en = e; v.flush = f;
    v.exp_comp = c; v.exp_tag = et; v.exp_cnt = n; v.exp_full = fl;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input vec_t v);
    check({name, ".complete"}, 32'(complete_o), 32'(v.exp_comp));
    check({name, ".tag"},      32'(tag_o),      32'(v.exp_tag));
    check({name, ".count"},    32'(count_o),    32'(v.exp_cnt));
    check({name, ".full"},     32'(full_o),     32'(v.exp_full));
  endtask

  // Entered on a falling edge: drive the inputs, wait for the rising edge,
  // then compare on the following falling edge.
  task automatic run(input vec_t v, input string name);
    push_i        = v.push;
    push_tag_i    = v.tag;
    complete_en_i = v.en;
    flush_i       = v.flush;
    @(posedge clk);
    @(negedge clk);
    check_outs(name, v);
  endtask

  // A request may never be raised on two consecutive rising edges.
  logic prev_comp = 1'b0;
  always @(posedge clk) begin
    if (reset === 1'b1) begin
      checks++;
      if (prev_comp && complete_o) begin
        errors++;
        $display("FAIL back_to_back_complete: got complete_o=1 on two consecutive edges, expected 0 on the second");
      end
      prev_comp = complete_o;
    end else begin
      prev_comp = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; push_i = 1'b0; push_tag_i = '0; complete_en_i = 1'b0; flush_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outs("reset", mk(0, 0, 0, 0, 0, 6'h00, 0, 0));
    reset = 1'b1;

`ifndef CB_BYPASS_EN
    // Single push: the request is raised one cycle later, and the grant pops the tag.
    tbl.push_back(mk(1, 6'h15, 0, 0,  1, 6'h15, 1, 0));
    tbl.push_back(mk(0, 6'h00, 0, 0,  0, 6'h15, 1, 0));
    tbl.push_back(mk(0, 6'h00, 1, 0,  0, 6'h00, 0, 0));
    // Grant seen in IDLE: it is ignored.
    tbl.push_back(mk(0, 6'h00, 1, 0,  0, 6'h00, 0, 0));
    // Four pushes with the first grant withheld fill the buffer. A 5th push
    // (0x07) while full is dropped even though it coincides with a pop.
    tbl.push_back(mk(1, 6'h03, 0, 0,  1, 6'h03, 1, 0));
    tbl.push_back(mk(1, 6'h04, 0, 0,  0, 6'h03, 2, 0));
    tbl.push_back(mk(1, 6'h05, 0, 0,  1, 6'h03, 3, 0));
    tbl.push_back(mk(1, 6'h06, 0, 0,  0, 6'h03, 4, 1));
    tbl.push_back(mk(1, 6'h07, 1, 0,  1, 6'h04, 3, 0));
    tbl.push_back(mk(0, 6'h00, 0, 0,  0, 6'h04, 3, 0));
    tbl.push_back(mk(0, 6'h00, 1, 0,  1, 6'h05, 2, 0));
    tbl.push_back(mk(0, 6'h00, 0, 0,  0, 6'h05, 2, 0));
    tbl.push_back(mk(0, 6'h00, 1, 0,  1, 6'h06, 1, 0));
    tbl.push_back(mk(0, 6'h00, 0, 0,  0, 6'h06, 1, 0));
    tbl.push_back(mk(0, 6'h00, 1, 0,  0, 6'h00, 0, 0));
    tbl.push_back(mk(0, 6'h00, 0, 0,  0, 6'h00, 0, 0));
    // Denied grant: 0x2A is re-offered. Then a push and a pop in the same
    // cycle leave the count unchanged.
    tbl.push_back(mk(1, 6'h2A, 0, 0,  1, 6'h2A, 1, 0));
    tbl.push_back(mk(0, 6'h00, 0, 0,  0, 6'h2A, 1, 0));
    tbl.push_back(mk(0, 6'h00, 0, 0,  1, 6'h2A, 1, 0));
    tbl.push_back(mk(0, 6'h00, 0, 0,  0, 6'h2A, 1, 0));
    tbl.push_back(mk(1, 6'h2B, 1, 0,  1, 6'h2B, 1, 0));
    tbl.push_back(mk(0, 6'h00, 0, 0,  0, 6'h2B, 1, 0));
    tbl.push_back(mk(0, 6'h00, 1, 0,  0, 6'h00, 0, 0));

    for (int i = 0; i < tbl.size(); i++) run(tbl[i], $sformatf("vec%0d", i));

    // Flush in WAIT with 3 entries. The late grant that follows must not pop.
    run(mk(1, 6'h31, 0, 0,  1, 6'h31, 1, 0), "fl_push1");
    run(mk(1, 6'h32, 0, 0,  0, 6'h31, 2, 0), "fl_push2");
    run(mk(1, 6'h33, 0, 0,  1, 6'h31, 3, 0), "fl_push3");
    run(mk(0, 6'h00, 0, 0,  0, 6'h31, 3, 0), "fl_wait");
    run(mk(0, 6'h00, 0, 1,  0, 6'h00, 0, 0), "fl_flush");
    run(mk(0, 6'h00, 1, 0,  0, 6'h00, 0, 0), "fl_late_grant");
    run(mk(0, 6'h00, 0, 0,  0, 6'h00, 0, 0), "fl_idle");
    // After the flush, the pointers restart cleanly.
    run(mk(1, 6'h3C, 0, 0,  1, 6'h3C, 1, 0), "fl_repush");
    run(mk(0, 6'h00, 0, 0,  0, 6'h3C, 1, 0), "fl_rewait");
    run(mk(0, 6'h00, 1, 0,  0, 6'h00, 0, 0), "fl_repop");
    // A flush beats a push in the same cycle.
    run(mk(1, 6'h3D, 0, 1,  0, 6'h00, 0, 0), "fl_push_flush");
    run(mk(0, 6'h00, 0, 0,  0, 6'h00, 0, 0), "fl_after");
`else
    // Bypass: a push into an empty, idle buffer is offered in the same cycle.
    push_i = 1'b1; push_tag_i = 6'h11;
    #1;
    check("byp.complete", 32'(complete_o), 32'd1);
    check("byp.tag",      32'(tag_o),      32'h11);
    check("byp.count",    32'(count_o),    32'd0);
    @(posedge clk);
    @(negedge clk);
    push_i = 1'b0; push_tag_i = '0;
    #1;
    check("byp_wait.complete", 32'(complete_o), 32'd0);
    check("byp_wait.tag",      32'(tag_o),      32'h11);
    check("byp_wait.count",    32'(count_o),    32'd1);
    run(mk(0, 6'h00, 1, 0,  0, 6'h00, 0, 0), "byp_grant");
    run(mk(0, 6'h00, 0, 0,  0, 6'h00, 0, 0), "byp_idle");
`endif

    push_i = 1'b0; complete_en_i = 1'b0; flush_i = 1'b0;
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
